moving_average_filter: RTL

Parametrised boxcar (moving-average) low-pass filter over N = 2^LOG2_N signed samples, computed with a running-sum accumulator and circular sample buffer instead of an N-input adder tree. It sits between the ADC capture/scaling stage and the hybrid-control logic, replacing the fixed 4- and 32-tap averagers. It adds a sample-enable handshake, a synchronous flush, round-to-nearest division and a settled flag.

---
 rtl/mavg_pkg.sv | 31 +++
 rtl/mavg_delay_line.sv | 58 +++++
 rtl/moving_average_filter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mavg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mavg_pkg
//  Description : Shared sizing helpers and parameter range checks for the
//                moving-average filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mavg_pkg;

    // Accumulator width: one extra bit per doubling of the window.
    function automatic int acc_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

    // Constant added before the divide: half an LSB of the quotient, or zero.
    function automatic int round_const(input int log2_n, input int round);
        return (round != 0) ? (1 << (log2_n - 1)) : 0;
    endfunction

    // Window length must stay in 2..64 samples.
    function automatic bit log2_n_ok(input int log2_n);
        return (log2_n >= 1) && (log2_n <= 6);
    endfunction

    // Sample width must stay in 8..32 bits.
    function automatic bit data_w_ok(input int data_w);
        return (data_w >= 8) && (data_w <= 32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mavg_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : mavg_delay_line
//  Description : Circular buffer of 2^LOG2_N samples. Presents the oldest
//                sample (the one about to be overwritten) combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module mavg_delay_line
    import mavg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LOG2_N = 5
) (
    input  logic              i_clock,
    input  logic              i_RESET,
    input  logic              i_we,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_oldest
);

    localparam int              c_n       = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] c_ptr_one = LOG2_N'(1);

    logic [DATA_W-1:0] r_buf_q [c_n];
    logic [DATA_W-1:0] w_buf_d [c_n];
    logic [LOG2_N-1:0] r_wptr_q;
    logic [LOG2_N-1:0] w_wptr_d;

    // Read uses pre-edge contents, so the slot is read and rewritten in one cycle.
    assign o_oldest = r_buf_q[r_wptr_q];

    // Next buffer contents and pointer: flush to zero, or write and advance.
    always_comb begin
        w_buf_d  = r_buf_q;
        w_wptr_d = r_wptr_q;
        if (i_clear) begin
            w_buf_d  = '{default: '0};
            w_wptr_d = '0;
        end else if (i_we) begin
            w_buf_d[r_wptr_q] = i_data;
            w_wptr_d          = r_wptr_q + c_ptr_one;
        end
    end

    // Buffer and pointer registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_RESET) begin
            r_buf_q  <= '{default: '0};
            r_wptr_q <= '0;
        end else begin
            r_buf_q  <= w_buf_d;
            r_wptr_q <= w_wptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/moving_average_filter.sv
`default_nettype none
// ============================================================================
//  Module      : moving_average_filter
//  Description : Boxcar low-pass filter over 2^LOG2_N signed samples using a
//                running-sum accumulator, optional round-half-up divide,
//                synchronous flush and a settled flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module moving_average_filter
    import mavg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LOG2_N = 5,
    parameter int ROUND  = 1
) (
    input  logic              i_clock,
    input  logic              i_RESET,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_mean,
    output logic              o_valid,
    output logic              o_settled
);

    localparam int                   ACC_W     = acc_w(DATA_W, LOG2_N);
    localparam logic signed [ACC_W-1:0] c_round = ACC_W'(round_const(LOG2_N, ROUND));
    localparam logic [LOG2_N:0]      c_cnt_one = (LOG2_N + 1)'(1);
    localparam logic [LOG2_N:0]      c_n       = c_cnt_one << LOG2_N;

    if (!log2_n_ok(LOG2_N)) begin : g_bad_log2_n
        $error("moving_average_filter: LOG2_N out of range 1..6");
    end
    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("moving_average_filter: DATA_W out of range 8..32");
    end

    logic signed [ACC_W-1:0] r_acc_q,  w_acc_d;
    logic [LOG2_N:0]         r_cnt_q,  w_cnt_d;
    logic [DATA_W-1:0]       r_mean_q, w_mean_d;
    logic                    r_valid_q, w_valid_d;
    logic                    r_settled_q, w_settled_d;

    logic [DATA_W-1:0]       w_oldest;
    logic signed [ACC_W-1:0] w_in_ext;
    logic signed [ACC_W-1:0] w_old_ext;
    logic signed [ACC_W-1:0] w_acc_n;
    logic signed [ACC_W-1:0] w_rounded;
    logic [DATA_W-1:0]       w_mean_n;
    logic                    w_accept;

    // Clear wins over a simultaneous sample.
    assign w_accept = i_valid && !i_clear;

    mavg_delay_line #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_delay_line (
        .i_clock  (i_clock),
        .i_RESET  (i_RESET),
        .i_we     (w_accept),
        .i_clear  (i_clear),
        .i_data   (i_data),
        .o_oldest (w_oldest)
    );

    // The accumulator is wide enough that even rounded full-scale sums never wrap.
    assign w_in_ext  = {{LOG2_N{i_data[DATA_W-1]}}, i_data};
    assign w_old_ext = {{LOG2_N{w_oldest[DATA_W-1]}}, w_oldest};
    assign w_acc_n   = r_acc_q + w_in_ext - w_old_ext;
    assign w_rounded = w_acc_n + c_round;
    assign w_mean_n  = DATA_W'(w_rounded >>> LOG2_N);

    // Next-state for accumulator, fill counter and output registers.
    always_comb begin
        w_acc_d     = r_acc_q;
        w_cnt_d     = r_cnt_q;
        w_mean_d    = r_mean_q;
        w_valid_d   = 1'b0;
        w_settled_d = r_settled_q;
        if (i_clear) begin
            w_acc_d     = '0;
            w_cnt_d     = '0;
            w_mean_d    = '0;
            w_settled_d = 1'b0;
        end else if (i_valid) begin
            w_acc_d     = w_acc_n;
            w_cnt_d     = (r_cnt_q == c_n) ? c_n : (r_cnt_q + c_cnt_one);
            w_mean_d    = w_mean_n;
            w_valid_d   = 1'b1;
            w_settled_d = (w_cnt_d == c_n);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_RESET) begin
            r_acc_q     <= '0;
            r_cnt_q     <= '0;
            r_mean_q    <= '0;
            r_valid_q   <= 1'b0;
            r_settled_q <= 1'b0;
        end else begin
            r_acc_q     <= w_acc_d;
            r_cnt_q     <= w_cnt_d;
            r_mean_q    <= w_mean_d;
            r_valid_q   <= w_valid_d;
            r_settled_q <= w_settled_d;
        end
    end

    assign o_mean    = r_mean_q;
    assign o_valid   = r_valid_q;
    assign o_settled = r_settled_q;

endmodule
`default_nettype wire
